mmcm_ps_responder: RTL and testbench
====================================

Name: mmcm_ps_responder

Overview:
Synthesizable model of the MMCM dynamic phase-shift (DPS) port. It responds to psen/psincdec, the pulse train the phase-shifter controller produces.
- Returns psdone after the MMCM's fixed latency.
- Tracks the accumulated fine-phase position modulo one period.
- Flags protocol violations.
- Used in loopback builds and benches to close the DPS handshake without a real MMCM.
- Exposes a 32-bit status word for the AXI status register.

Parameters:
PS_LATENCY, 12, psclk cycles from sampled psen to psdone; legal range 2..255
PERIOD_STEPS, 1120, number of fine steps in one full output period; phase wraps modulo this; legal range 2..65535

Ports:
clk  input  1  DPS clock; all logic on rising edge
resetn  input  1  asynchronous active-low reset
psen  input  1  phase-shift request, one-cycle pulse
psincdec  input  1  direction, sampled with psen; 1 = increment, 0 = decrement
clr  input  1  synchronous clear of the overrun flag
psdone  output  1  one-cycle completion pulse, registered
busy  output  1  high while a shift is in flight
phase  output  16  current phase position, 0..PERIOD_STEPS-1
overrun  output  1  sticky: psen seen while busy
sts  output  32  {shift_count[11:0], 2'b00, overrun, busy, phase[15:0]}

Behaviour:
- Reset (resetn low, asynchronous):
  - Outputs: psdone=0, busy=0, phase=0, overrun=0, shift_count=0, state=IDLE.
  - Latency counter=0.
  - A pending shift is discarded; no psdone is emitted after reset release.
- FSM has two states, IDLE and WAIT.
- IDLE:
  - When psen=1 at a clock edge, latch psincdec into dir and load the latency counter with PS_LATENCY-1.
  - Go to WAIT; busy=1 from the next cycle.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle where counter==0, psdone=1 for exactly that cycle.
  - At the end of that cycle: update phase, increment shift_count, go to IDLE, busy=0.
- Latency: psen high in cycle 0 gives psdone high in cycle PS_LATENCY. The updated phase and shift_count are visible in cycle PS_LATENCY+1.
- Back-to-back: psen in the first IDLE cycle after psdone is accepted normally. The minimum legal request spacing is PS_LATENCY+1 cycles.
- psen while in WAIT, including the psdone cycle:
  - The request is ignored; no extra shift, and dir is unchanged.
  - overrun is set to 1 on the next cycle.
- overrun stays set until clr=1. If clr and a new violation occur in the same cycle, set wins.
- Phase arithmetic:
  - Unsigned 16-bit value, always in 0..PERIOD_STEPS-1.
  - Increment: PERIOD_STEPS-1 wraps to 0.
  - Decrement: 0 wraps to PERIOD_STEPS-1.
- shift_count: 12-bit, wraps 4095 -> 0, counts completed shifts of either direction.
- psincdec is only sampled together with an accepted psen. Changes at other times have no effect.
- sts is a combinational concatenation of the registered fields; no extra latency.

Test Plan:
1. Reset release, then a single psen with psincdec=1 in cycle 0 -> busy=1 in cycles 1..12; psdone=1 only in cycle 12; in cycle 13, phase=1, shift_count=1, busy=0, sts=0x00100001.
2. A controller-style train: 3 psen pulses every 16 cycles, psincdec=1, then 5 pulses every 16 cycles, psincdec=0 -> 8 psdone pulses, each 12 cycles after its psen; final phase=1118 (0-wrap), shift_count=8, overrun=0.
3. Pulses spaced 8 cycles apart, 4 requests -> requests 2 and 4 are ignored; 2 psdone pulses; shift_count=2; overrun=1. Then clr=1 for one cycle -> overrun=0. clr asserted in the same cycle as a violating psen -> overrun stays 1.
4. Wrap: PERIOD_STEPS=4, 5 increments at legal spacing -> phase sequence 1,2,3,0,1. From 0, one decrement -> 3.
5. resetn asserted in cycle 6 of a WAIT -> all outputs 0 immediately; no psdone in the following 20 cycles; phase=0.
6. Spacing exactly PS_LATENCY+1: psen at cycles 0 and 13 -> both accepted; psdone at cycles 12 and 25; overrun=0. psen at cycle 12 (the psdone cycle) -> ignored and overrun=1.

Source files
------------

// File: rtl/mmcm_ps_responder.sv
// ---------------------------------------------------------------------------
// mmcm_ps_responder
//
// Stands in for the dynamic phase-shift (DPS) port of an MMCM. It answers each
// accepted psen with a one-cycle psdone after a fixed latency. It tracks the
// accumulated fine-phase position modulo one output period. It also raises a
// sticky flag when a request arrives while a shift is still in flight.
//
// Handshake: a request is a single-cycle psen pulse, with psincdec valid in
// that same cycle. It is accepted only when the block is idle (busy=0). The
// completion is a single-cycle psdone pulse exactly PS_LATENCY cycles after
// the accepted psen. A psen seen while busy=1, including the psdone cycle, is
// dropped and sets overrun.
//
// Parameters:
//   PS_LATENCY    cycles from sampled psen to psdone (2..255)
//   PERIOD_STEPS  fine steps per output period; phase wraps modulo this
//                 value (2..65535)
//
// Ports:
//   clk       DPS clock, rising edge
//   resetn    asynchronous active-low reset
//   psen      phase-shift request pulse
//   psincdec  direction sampled with psen (1 = increment, 0 = decrement)
//   clr       synchronous clear of overrun (a new violation wins)
//   psdone    registered one-cycle completion pulse
//   busy      high while a shift is in flight
//   phase     current phase position, 0..PERIOD_STEPS-1
//   overrun   sticky protocol-violation flag
//   sts       {shift_count[11:0], 2'b00, overrun, busy, phase[15:0]}
// ---------------------------------------------------------------------------
module mmcm_ps_responder #(
    parameter int unsigned PS_LATENCY   = 12,
    parameter int unsigned PERIOD_STEPS = 1120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        psen,
    input  logic        psincdec,
    input  logic        clr,
    output logic        psdone,
    output logic        busy,
    output logic [15:0] phase,
    output logic        overrun,
    output logic [31:0] sts
);

    // Catch illegal parameterisations at elaboration time.
    if (PS_LATENCY < 2 || PS_LATENCY > 255) begin : g_bad_latency
        $error("mmcm_ps_responder: PS_LATENCY out of range 2..255");
    end
    if (PERIOD_STEPS < 2 || PERIOD_STEPS > 65535) begin : g_bad_period
        $error("mmcm_ps_responder: PERIOD_STEPS out of range 2..65535");
    end

    // The counter is loaded with PS_LATENCY-1 in the accept cycle. It then
    // counts down once per cycle in WAIT, so it reaches zero in cycle
    // PS_LATENCY.
    localparam logic [7:0]  LOAD_CNT   = 8'(PS_LATENCY - 1);
    localparam logic [15:0] LAST_PHASE = 16'(PERIOD_STEPS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nx;
    logic        dir;
    logic        dir_nx;
    logic [15:0] phase_nx;
    logic [11:0] shift_count;
    logic [11:0] shift_count_nx;
    logic        overrun_nx;
    logic        psdone_nx;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            dir         <= 1'b0;
            phase       <= 16'd0;
            shift_count <= 12'd0;
            overrun     <= 1'b0;
            psdone      <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            dir         <= dir_nx;
            phase       <= phase_nx;
            shift_count <= shift_count_nx;
            overrun     <= overrun_nx;
            psdone      <= psdone_nx;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        dir_nx         = dir;
        phase_nx       = phase;
        shift_count_nx = shift_count;
        overrun_nx     = overrun;

        // The clear is applied first so that a violation in the same cycle
        // overrides it below.
        if (clr) begin
            overrun_nx = 1'b0;
        end

        case (state)
            IDLE: begin
                if (psen) begin
                    dir_nx   = psincdec;
                    cnt_nx   = LOAD_CNT;
                    state_nx = WAIT;
                end
            end

            WAIT: begin
                // Any request while in flight is dropped. That includes a
                // request in the psdone cycle.
                if (psen) begin
                    overrun_nx = 1'b1;
                end

                if (cnt == 8'd0) begin
                    // This is the psdone cycle. The shift is committed on
                    // the edge that ends it.
                    if (dir) begin
                        phase_nx = (phase == LAST_PHASE) ? 16'd0 : phase + 16'd1;
                    end else begin
                        phase_nx = (phase == 16'd0) ? LAST_PHASE : phase - 16'd1;
                    end
                    shift_count_nx = shift_count + 12'd1;
                    state_nx       = IDLE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        // psdone is registered. It is raised for the cycle in which the
        // counter will sit at zero in WAIT. LOAD_CNT is never zero, so an
        // accept cycle cannot trigger it.
        psdone_nx = (state_nx == WAIT) && (cnt_nx == 8'd0);
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy = (state == WAIT);
    assign sts  = {shift_count, 2'b00, overrun, busy, phase};

endmodule

// File: tb/tb_mmcm_ps_responder.sv
// ---------------------------------------------------------------------------
// tb_mmcm_ps_responder
//
// Two instances share the same stimulus. dut_a uses the default parameters
// (PS_LATENCY=12, PERIOD_STEPS=1120). dut_b uses PERIOD_STEPS=4 so that the
// phase wrap is reached quickly.
//
// When the driver issues an accepted request, it pushes the expected psdone
// cycle and the expected post-shift state into exp_q. The monitor pops one
// entry on every psdone and compares the cycle number. On the following
// cycle it compares phase, shift_count and busy. Directed checks with
// hand-computed constants sit in the main sequence.
// ---------------------------------------------------------------------------
module tb_mmcm_ps_responder;

    localparam int L  = 12;
    localparam int P  = 1120;
    localparam int P4 = 4;
    localparam int W  = 76;   // {cycle[31:0], phase_a[15:0], phase_b[15:0], count[11:0]}

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic psen = 1'b0;
    logic psincdec = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        psdone_a, busy_a, overrun_a;
    logic [15:0] phase_a;
    logic [31:0] sts_a;
    logic        psdone_b, busy_b, overrun_b;
    logic [15:0] phase_b;
    logic [31:0] sts_b;

    mmcm_ps_responder #(.PS_LATENCY(L), .PERIOD_STEPS(P)) dut_a (
        .clk(clk), .resetn(resetn), .psen(psen), .psincdec(psincdec), .clr(clr),
        .psdone(psdone_a), .busy(busy_a), .phase(phase_a), .overrun(overrun_a), .sts(sts_a)
    );

    mmcm_ps_responder #(.PS_LATENCY(L), .PERIOD_STEPS(P4)) dut_b (
        .clk(clk), .resetn(resetn), .psen(psen), .psincdec(psincdec), .clr(clr),
        .psdone(psdone_b), .busy(busy_b), .phase(phase_b), .overrun(overrun_b), .sts(sts_b)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    int   m_phase = 0;
    int   m_phase4 = 0;
    int   m_count = 0;
    int   last_acc = -1000;
    logic m_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------------
    // Driver tasks (called at a negedge, return at the next negedge)
    // -----------------------------------------------------------------------
    task automatic pulse(input logic dir, input logic clr_v);
        logic [31:0] done_cyc;
        psen     = 1'b1;
        psincdec = dir;
        clr      = clr_v;
        if (cyc >= last_acc + L + 1) begin
            last_acc = cyc;
            if (dir) begin
                m_phase  = (m_phase == P - 1) ? 0 : m_phase + 1;
                m_phase4 = (m_phase4 == P4 - 1) ? 0 : m_phase4 + 1;
            end else begin
                m_phase  = (m_phase == 0) ? P - 1 : m_phase - 1;
                m_phase4 = (m_phase4 == 0) ? P4 - 1 : m_phase4 - 1;
            end
            m_count  = (m_count + 1) % 4096;
            done_cyc = 32'(cyc + L);
            exp_q.push_back({done_cyc, 16'(m_phase), 16'(m_phase4), 12'(m_count)});
            if (clr_v) m_ovr = 1'b0;
        end else begin
            m_ovr = 1'b1;
        end
        @(negedge clk);
        psen     = 1'b0;
        clr      = 1'b0;
        // Direction toggles outside requests must not matter.
        psincdec = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear();
        clr = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        m_ovr = 1'b0;
        check("clr_overrun", {31'd0, overrun_a}, 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        exp_q.delete();
        m_phase  = 0;
        m_phase4 = 0;
        m_count  = 0;
        last_acc = -1000;
        m_ovr    = 1'b0;
        #1;
        check("reset_sts_a", sts_a, 32'd0);
        check("reset_sts_b", sts_b, 32'd0);
        check("reset_psdone", {30'd0, psdone_a, psdone_b}, 32'd0);
        idle(2);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    logic drain_pend;

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || drain_pend) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    logic [W-1:0] cur;

    initial drain_pend = 1'b0;

    always @(negedge clk) begin
        if (!resetn) begin
            drain_pend = 1'b0;
        end else begin
            if (drain_pend) begin
                drain_pend = 1'b0;
                check("post_phase_a", {16'd0, sts_a[15:0]}, {16'd0, cur[43:28]});
                check("post_phase_b", {16'd0, sts_b[15:0]}, {16'd0, cur[27:12]});
                check("post_count_a", {20'd0, sts_a[31:20]}, {20'd0, cur[11:0]});
                check("post_busy_a", {31'd0, busy_a}, 32'd0);
            end
            if (psdone_a || psdone_b) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_psdone: got a=%0b b=%0b expected none (cycle %0d)",
                             psdone_a, psdone_b, cyc);
                end else begin
                    cur = exp_q.pop_front();
                    check("psdone_cycle", 32'(cyc), cur[75:44]);
                    check("psdone_pair", {30'd0, psdone_a, psdone_b}, 32'd3);
                    drain_pend = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        logic [15:0] wrap_seq [7];
        wrap_seq = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd0, 16'd3};

        do_reset();

        // Single increment: busy in cycles 1..12, sts in cycle 13.
        pulse(1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            check("t1_busy", {31'd0, busy_a}, 32'd1);
            @(negedge clk);
        end
        check("t1_sts", sts_a, 32'h0010_0001);

        // Controller-style train: 3 up, 5 down, 16-cycle spacing.
        do_reset();
        for (int i = 0; i < 3; i++) begin pulse(1'b1, 1'b0); idle(15); end
        for (int i = 0; i < 5; i++) begin pulse(1'b0, 1'b0); idle(15); end
        drain();
        check("t2_phase", {16'd0, phase_a}, 32'd1118);
        check("t2_count", {20'd0, sts_a[31:20]}, 32'd8);
        check("t2_overrun", {31'd0, overrun_a}, 32'd0);
        check("t2_phase_b", {16'd0, phase_b}, 32'd2);

        // Minimum spacing, then a request in the psdone cycle.
        pulse(1'b1, 1'b0);          // cycle c
        idle(11);
        pulse(1'b1, 1'b0);          // cycle c+12, a violation
        pulse(1'b1, 1'b0);          // cycle c+13, accepted
        check("t6_overrun_mid", {31'd0, overrun_a}, 32'd1);
        clear();
        idle(10);                   // now in cycle c+25 (psdone)
        check("t6_overrun_pre", {31'd0, overrun_a}, 32'd0);
        pulse(1'b0, 1'b0);          // dropped
        check("t6_overrun", {31'd0, overrun_a}, 32'd1);
        drain();
        check("t6_phase", {16'd0, phase_a}, 32'd0);
        check("t6_phase_b", {16'd0, phase_b}, 32'd0);
        check("t6_count", {20'd0, sts_a[31:20]}, 32'd10);
        check("t6_overrun_model", {31'd0, overrun_a}, {31'd0, m_ovr});
        clear();

        // 8-cycle spacing: the 2nd and 4th requests are dropped.
        do_reset();
        pulse(1'b1, 1'b0); idle(7);
        pulse(1'b0, 1'b0); idle(7);
        pulse(1'b1, 1'b0); idle(7);
        pulse(1'b0, 1'b0);
        drain();
        check("t3_count", {20'd0, sts_a[31:20]}, 32'd2);
        check("t3_phase", {16'd0, phase_a}, 32'd2);
        check("t3_overrun", {31'd0, overrun_a}, 32'd1);
        clear();
        pulse(1'b1, 1'b0);
        idle(2);
        pulse(1'b0, 1'b1);          // clr together with a violation: set wins
        check("t3_set_wins", {31'd0, overrun_a}, 32'd1);
        drain();
        check("t3_set_wins_late", {31'd0, overrun_a}, 32'd1);
        check("t3_phase_late", {16'd0, phase_a}, 32'd3);

        // Wrap on the 4-step instance: 1,2,3,0,1 up, then 0,3 down.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            pulse((i < 5) ? 1'b1 : 1'b0, 1'b0);
            idle(12);
            drain();
            check("t4_wrap_b", {16'd0, phase_b}, {16'd0, wrap_seq[i]});
        end
        check("t4_phase_a", {16'd0, phase_a}, 32'd3);

        // Reset asserted in cycle 6 of a WAIT.
        do_reset();
        pulse(1'b1, 1'b0);
        idle(5);
        check("t5_busy_before", {31'd0, busy_a}, 32'd1);
        do_reset();
        idle(20);
        check("t5_phase", {16'd0, phase_a}, 32'd0);
        check("t5_sts", sts_a, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
